// File: rtl/ifetch_pkg.sv
// Shared widths, credit limit and response record for the instruction-fetch
// request scheduler.
package ifetch_pkg;

    localparam int PC_W    = 32;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] inst;
    } resp_t;

endpackage

// File: rtl/ifetch_req_sched_if.sv
// Fetch-request, inst-cache and decode-side signals of the fetch scheduler.
interface ifetch_req_sched_if;
    import ifetch_pkg::*;

    logic              fetch_valid_i;
    logic [PC_W-1:0]   fetch_pc_i;
    logic              fetch_ready_o;
    logic              icache_req_o;
    logic [PC_W-1:0]   icache_addr_o;
    logic              icache_addr_ok_i;
    logic              icache_data_ok_i;
    logic [DATA_W-1:0] icache_rdata_i;
    logic              flush_i;
    logic              resp_valid_o;
    logic [PC_W-1:0]   resp_pc_o;
    logic [DATA_W-1:0] resp_inst_o;
    logic              resp_ready_i;
    logic [CNT_W-1:0]  live_cnt_o;
    logic [CNT_W-1:0]  cancel_cnt_o;
    logic              error_o;

    modport slave (
        input  fetch_valid_i, fetch_pc_i, icache_addr_ok_i, icache_data_ok_i,
               icache_rdata_i, flush_i, resp_ready_i,
        output fetch_ready_o, icache_req_o, icache_addr_o, resp_valid_o,
               resp_pc_o, resp_inst_o, live_cnt_o, cancel_cnt_o, error_o
    );

    modport master (
        output fetch_valid_i, fetch_pc_i, icache_addr_ok_i, icache_data_ok_i,
               icache_rdata_i, flush_i, resp_ready_i,
        input  fetch_ready_o, icache_req_o, icache_addr_o, resp_valid_o,
               resp_pc_o, resp_inst_o, live_cnt_o, cancel_cnt_o, error_o
    );
endinterface

// File: rtl/ifetch_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear and an occupancy count.
module ifetch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the slot a same-cycle push needs, so push-when-full is legal
    // only together with a pop.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; entries are only observed once count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_req_sched.sv
// Instruction-fetch request scheduler: credit-limited issue, central live/cancel
// tracking, stale data_ok discard and a response buffer toward decode.
module ifetch_req_sched
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ifetch_req_sched_if.slave bus
);
    localparam int OCC_W = CNT_W + 2;

    logic [CNT_W-1:0] live_cnt, cancel_cnt, live_next, cancel_next;
    logic [CNT_W-1:0] pcq_cnt, resp_cnt, resp_next;
    logic [OCC_W-1:0] occ, occ_next;
    logic [PC_W-1:0]  pcq_head;
    logic             error_q, err_set;
    logic             issue, stale, live_ret, spurious, resp_push, resp_pop;
    resp_t            resp_in, resp_head;

    assign occ = OCC_W'(live_cnt) + OCC_W'(cancel_cnt) + OCC_W'(resp_cnt);

    // Flush blocks the request so nothing new is issued into a dying stream.
    assign bus.icache_req_o  = bus.fetch_valid_i & ~bus.flush_i & (occ < OCC_W'(MAX_OUT));
    assign bus.icache_addr_o = bus.fetch_pc_i;
    assign issue             = bus.icache_req_o & bus.icache_addr_ok_i;
    assign bus.fetch_ready_o = issue;

    assign stale    = bus.icache_data_ok_i & (cancel_cnt != '0);
    assign live_ret = bus.icache_data_ok_i & (cancel_cnt == '0) & (live_cnt != '0);
    assign spurious = bus.icache_data_ok_i & (cancel_cnt == '0) & (live_cnt == '0);

    assign resp_push = live_ret & ~bus.flush_i;
    assign resp_pop  = bus.resp_valid_o & bus.resp_ready_i & ~bus.flush_i;
    assign resp_in   = '{pc: pcq_head, inst: bus.icache_rdata_i};

    always_comb begin
        live_next   = live_cnt + CNT_W'(issue) - CNT_W'(live_ret);
        cancel_next = cancel_cnt - CNT_W'(stale);
        resp_next   = resp_cnt + CNT_W'(resp_push) - CNT_W'(resp_pop);
        if (bus.flush_i) begin
            // Every live request still owed a data_ok becomes a cancelled one.
            live_next   = '0;
            cancel_next = cancel_cnt + live_cnt - CNT_W'(live_ret) - CNT_W'(stale);
            resp_next   = '0;
        end
        occ_next = OCC_W'(live_next) + OCC_W'(cancel_next) + OCC_W'(resp_next);
        err_set  = spurious | (occ_next > OCC_W'(MAX_OUT)) | (pcq_cnt != live_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_cnt   <= '0;
            cancel_cnt <= '0;
            error_q    <= 1'b0;
        end else begin
            live_cnt   <= live_next;
            cancel_cnt <= cancel_next;
            error_q    <= error_q | err_set;
        end
    end

    ifetch_sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUT), .CNT_W(CNT_W)) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush_i),
        .push      (issue),
        .push_data (bus.fetch_pc_i),
        .pop       (live_ret),
        .head      (pcq_head),
        .count     (pcq_cnt)
    );

    ifetch_sync_fifo #(.WIDTH(PC_W + DATA_W), .DEPTH(MAX_OUT), .CNT_W(CNT_W)) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush_i),
        .push      (resp_push),
        .push_data (resp_in),
        .pop       (resp_pop),
        .head      (resp_head),
        .count     (resp_cnt)
    );

    assign bus.resp_valid_o = (resp_cnt != '0);
    assign bus.resp_pc_o    = resp_head.pc;
    assign bus.resp_inst_o  = resp_head.inst;
    assign bus.live_cnt_o   = live_cnt;
    assign bus.cancel_cnt_o = cancel_cnt;
    assign bus.error_o      = error_q;

endmodule

// File: tb/tb_ifetch_req_sched.sv
// Directed vector table plus hand-written reset and back-to-back sequences.
module tb_ifetch_req_sched;
    import ifetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ifetch_req_sched_if bus();
    ifetch_req_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic              fv;
        logic [PC_W-1:0]   pc;
        logic              aok;
        logic              dok;
        logic [DATA_W-1:0] rdata;
        logic              fl;
        logic              rr;
        logic              e_req;
        logic              e_rv;
        logic [PC_W-1:0]   e_pc;
        logic [DATA_W-1:0] e_inst;
        logic [CNT_W-1:0]  e_live;
        logic [CNT_W-1:0]  e_cancel;
        logic              e_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [DATA_W-1:0] D1 = 64'h0000_0013_0000_0014;
    localparam logic [DATA_W-1:0] DA = 64'haaaa_0001_aaaa_0002;
    localparam logic [DATA_W-1:0] DB = 64'hbbbb_0003_bbbb_0004;
    localparam logic [DATA_W-1:0] DE = 64'heeee_0005_eeee_0006;

    function automatic vec_t mk(input logic fv, input logic [PC_W-1:0] pc, input logic aok,
                                input logic dok, input logic [DATA_W-1:0] rdata, input logic fl,
                                input logic rr, input logic e_req, input logic e_rv,
                                input logic [PC_W-1:0] e_pc, input logic [DATA_W-1:0] e_inst,
                                input logic [CNT_W-1:0] e_live, input logic [CNT_W-1:0] e_cancel,
                                input logic e_err);
        vec_t v;
        v.fv = fv; v.pc = pc; v.aok = aok; v.dok = dok; v.rdata = rdata; v.fl = fl; v.rr = rr;
        v.e_req = e_req; v.e_rv = e_rv; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_live = e_live; v.e_cancel = e_cancel; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [PC_W-1:0] pc, input logic aok,
                         input logic dok, input logic [DATA_W-1:0] rdata, input logic fl,
                         input logic rr);
        bus.fetch_valid_i    = fv;
        bus.fetch_pc_i       = pc;
        bus.icache_addr_ok_i = aok;
        bus.icache_data_ok_i = dok;
        bus.icache_rdata_i   = rdata;
        bus.flush_i          = fl;
        bus.resp_ready_i     = rr;
    endtask

    initial begin
        //            fv pc            aok dok rdata fl rr | req rv pc           inst live can err
        vecs.push_back(mk(1, 32'h1c000000, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 0, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(0, '0,           0, 1, D1, 0, 1,   0, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 0,   0, 1, 32'h1c000000, D1, 0, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 1, 32'h1c000000, D1, 0, 0, 0));
        // credit limit with decode stalled
        vecs.push_back(mk(1, 32'h1c000010, 1, 0, '0, 0, 0,   1, 0, '0,           '0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000018, 1, 0, '0, 0, 0,   1, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h1c000020, 0, 1, DA, 0, 0,   0, 0, '0,           '0, 2, 0, 0));
        vecs.push_back(mk(1, 32'h1c000020, 0, 1, DB, 0, 0,   0, 1, 32'h1c000010, DA, 1, 0, 0));
        vecs.push_back(mk(1, 32'h1c000020, 0, 0, '0, 0, 0,   0, 1, 32'h1c000010, DA, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000020, 0, 0, '0, 0, 1,   0, 1, 32'h1c000010, DA, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000020, 0, 0, '0, 0, 0,   1, 1, 32'h1c000018, DB, 0, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 1, 32'h1c000018, DB, 0, 0, 0));
        // flush with two live requests
        vecs.push_back(mk(1, 32'h1c000028, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000030, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h1c000034, 1, 0, '0, 1, 1,   0, 0, '0,           '0, 2, 0, 0));
        vecs.push_back(mk(0, '0,           0, 1, DE, 0, 1,   0, 0, '0,           '0, 0, 2, 0));
        vecs.push_back(mk(0, '0,           0, 1, DE, 0, 1,   0, 0, '0,           '0, 0, 1, 0));
        // flush coincident with a live data_ok
        vecs.push_back(mk(1, 32'h1c000038, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c00003c, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(0, '0,           0, 1, DA, 1, 1,   0, 0, '0,           '0, 2, 0, 0));
        // stale return ahead of a live one
        vecs.push_back(mk(1, 32'h1c000040, 1, 0, '0, 0, 1,   1, 0, '0,           '0, 0, 1, 0));
        vecs.push_back(mk(0, '0,           0, 1, DB, 0, 1,   0, 0, '0,           '0, 1, 1, 0));
        vecs.push_back(mk(0, '0,           0, 1, DE, 0, 0,   0, 0, '0,           '0, 1, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 1, 32'h1c000040, DE, 0, 0, 0));
        // spurious data_ok at idle
        vecs.push_back(mk(0, '0,           0, 1, DA, 0, 1,   0, 0, '0,           '0, 0, 0, 0));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 0, '0,           '0, 0, 0, 1));
        vecs.push_back(mk(0, '0,           0, 0, '0, 0, 1,   0, 0, '0,           '0, 0, 0, 1));

        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check("reset_live",   96'(bus.live_cnt_o),   96'(0));
        check("reset_cancel", 96'(bus.cancel_cnt_o), 96'(0));
        check("reset_error",  96'(bus.error_o),      96'(0));
        check("reset_rvalid", 96'(bus.resp_valid_o), 96'(0));
        check("reset_req",    96'(bus.icache_req_o), 96'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].aok, vecs[i].dok, vecs[i].rdata,
                  vecs[i].fl, vecs[i].rr);
            @(negedge clk);
            check($sformatf("v%0d_req", i),    96'(bus.icache_req_o),  96'(vecs[i].e_req));
            check($sformatf("v%0d_ready", i),  96'(bus.fetch_ready_o), 96'(vecs[i].e_req & vecs[i].aok));
            check($sformatf("v%0d_live", i),   96'(bus.live_cnt_o),    96'(vecs[i].e_live));
            check($sformatf("v%0d_cancel", i), 96'(bus.cancel_cnt_o),  96'(vecs[i].e_cancel));
            check($sformatf("v%0d_error", i),  96'(bus.error_o),       96'(vecs[i].e_err));
            check($sformatf("v%0d_rvalid", i), 96'(bus.resp_valid_o),  96'(vecs[i].e_rv));
            if (vecs[i].e_req)
                check($sformatf("v%0d_addr", i), 96'(bus.icache_addr_o), 96'(vecs[i].pc));
            if (vecs[i].e_rv) begin
                check($sformatf("v%0d_rpc", i),   96'(bus.resp_pc_o),   96'(vecs[i].e_pc));
                check($sformatf("v%0d_rinst", i), 96'(bus.resp_inst_o), 96'(vecs[i].e_inst));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-run with a live request and a set error flag.
        drive(1, 32'h1c000060, 1, 0, '0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0, '0, 0, 0);
        check("prerst_live",  96'(bus.live_cnt_o), 96'(1));
        check("prerst_error", 96'(bus.error_o),    96'(1));
        #1 rst_n = 1'b0;
        #1;
        check("arst_live",   96'(bus.live_cnt_o),   96'(0));
        check("arst_cancel", 96'(bus.cancel_cnt_o), 96'(0));
        check("arst_error",  96'(bus.error_o),      96'(0));
        check("arst_rvalid", 96'(bus.resp_valid_o), 96'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Issue and live data_ok on the same edge keep live_cnt and preserve order.
        drive(1, 32'h1c000080, 1, 0, '0, 0, 1);
        @(posedge clk);
        #1;
        drive(1, 32'h1c000088, 1, 1, DA, 0, 1);
        #1;
        check("b2b_ready", 96'(bus.fetch_ready_o), 96'(1));
        check("b2b_live0", 96'(bus.live_cnt_o),    96'(1));
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check("b2b_live1",  96'(bus.live_cnt_o),   96'(1));
        check("b2b_rvalid", 96'(bus.resp_valid_o), 96'(1));
        check("b2b_rpc0",   96'(bus.resp_pc_o),    96'(32'h1c000080));
        check("b2b_rinst0", 96'(bus.resp_inst_o),  96'(DA));
        @(posedge clk);
        #1;
        drive(0, '0, 0, 1, DB, 0, 1);
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0, '0, 0, 0);
        #1;
        check("b2b_rpc1",   96'(bus.resp_pc_o),   96'(32'h1c000088));
        check("b2b_rinst1", 96'(bus.resp_inst_o), 96'(DB));
        check("b2b_live2",  96'(bus.live_cnt_o),  96'(0));
        check("b2b_error",  96'(bus.error_o),     96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
